// File: rtl/adder_tree_accum.sv
// Pipelined NUM_IN-input adder tree with an optional running accumulator.
// Each tree level is one register stage. The tree is padded with zero leaves
// up to the next power of two. A single accumulate/output stage sits after
// the tree. Node arithmetic is either two's-complement add, which wraps, or
// an IEEE-754 add that rounds to nearest even. In float mode, 1+E+M is the
// operand format.
module adder_tree_accum #(
  parameter int ARITH_TYPE = 1,
  parameter int DATA_WIDTH = 32,
  parameter int E          = 8,
  parameter int M          = 23,
  parameter int NUM_IN     = 4,
  parameter int ACCUM      = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  input  logic                         in_last,
  input  logic [NUM_IN*DATA_WIDTH-1:0] in_data,
  output logic                         out_valid,
  output logic [DATA_WIDTH-1:0]        out_data
);

  localparam int L      = (NUM_IN > 1) ? $clog2(NUM_IN) : 0;
  localparam int LEAVES = 1 << L;
  localparam int FW     = 1 + E + M;
  localparam int XW     = E + 2;
  localparam int WW     = M + 5;

  // Float add with round-to-nearest-even. The working mantissa layout is
  // {carry, hidden, fraction, guard, round, sticky}.
  function automatic logic [DATA_WIDTH-1:0] fp_add(input logic [FW-1:0] a,
                                                   input logic [FW-1:0] b);
    logic          sa, sb, sr, sticky, rnd, a_nan, b_nan, a_inf, b_inf;
    logic [E-1:0]  ea, eb;
    logic [M-1:0]  fa, fb;
    logic [XW-1:0] xa, xb, xr, diff;
    logic [WW-1:0] wa, wb, wr;
    logic [M+1:0]  mr;
    logic [FW-1:0] fres;
    // Order the operands so that a has the larger magnitude.
    if (a[FW-2:0] < b[FW-2:0]) begin
      {sa, ea, fa} = b;
      {sb, eb, fb} = a;
    end else begin
      {sa, ea, fa} = a;
      {sb, eb, fb} = b;
    end
    a_nan = (ea == '1) && (fa != '0);
    b_nan = (eb == '1) && (fb != '0);
    a_inf = (ea == '1) && (fa == '0);
    b_inf = (eb == '1) && (fb == '0);
    xa = (ea == '0) ? XW'(1) : XW'(ea);
    xb = (eb == '0) ? XW'(1) : XW'(eb);
    wa = {1'b0, ea != '0, fa, 3'b000};
    wb = {1'b0, eb != '0, fb, 3'b000};
    diff = xa - xb;
    sticky = 1'b0;
    // Align the smaller operand. Bits shifted out are folded into sticky.
    for (int i = 0; i < WW; i++) begin
      if (XW'(i) < diff) begin
        sticky = sticky | wb[0];
        wb = wb >> 1;
      end
    end
    wb[0] = wb[0] | sticky;
    wr = (sa == sb) ? (wa + wb) : (wa - wb);
    xr = xa;
    sr = sa;
    // Normalise. Left shifts stop at the minimum exponent, which leaves a
    // subnormal result.
    if (wr[WW-1]) begin
      wr = {1'b0, wr[WW-1:2], wr[1] | wr[0]};
      xr = xr + XW'(1);
    end else begin
      for (int i = 0; i < WW; i++) begin
        if (!wr[WW-2] && (xr > XW'(1))) begin
          wr = wr << 1;
          xr = xr - XW'(1);
        end
      end
    end
    if (!wr[WW-2]) xr = '0;
    rnd = wr[2] & (wr[1] | wr[0] | wr[3]);
    mr  = {1'b0, wr[WW-2:3]} + (M+2)'(rnd);
    if (mr[M+1]) begin
      mr = mr >> 1;
      xr = xr + XW'(1);
    end else if ((xr == '0) && mr[M]) begin
      xr = XW'(1);
    end
    // An exact cancellation gives +0 unless both inputs were -0.
    if (mr == '0) sr = sa & sb;
    if (a_nan | b_nan | (a_inf & b_inf & (sa != sb)))
      fres = {1'b0, {E{1'b1}}, 1'b1, {(M-1){1'b0}}};
    else if (a_inf | b_inf)
      fres = {a_inf ? sa : sb, {E{1'b1}}, {M{1'b0}}};
    else if (xr >= {2'b00, {E{1'b1}}})
      fres = {sr, {E{1'b1}}, {M{1'b0}}};
    else
      fres = {sr, xr[E-1:0], mr[M-1:0]};
    return DATA_WIDTH'(fres);
  endfunction

  function automatic logic [DATA_WIDTH-1:0] node_add(input logic [DATA_WIDTH-1:0] a,
                                                     input logic [DATA_WIDTH-1:0] b);
    if (ARITH_TYPE == 1) return a + b;
    else return fp_add(FW'(a), FW'(b));
  endfunction

  logic [DATA_WIDTH-1:0] tree_sum, sum, acc;
  logic                  tree_v, tree_l, first;

  for (genvar l = 0; l <= L; l++) begin : g_lvl
    localparam int N = LEAVES >> l;
    logic [N*DATA_WIDTH-1:0] d;
    logic                    v, lst;
    if (l == 0) begin : g_leaf
      // Leaf level. Zero extension supplies the zero padding leaves, which
      // are also +0.0 in float mode.
      assign d   = (LEAVES*DATA_WIDTH)'(in_data);
      assign v   = in_valid;
      assign lst = in_valid & in_last;
    end else begin : g_node
      // Pairwise sums, low index first. The data registers are not reset
      // because v qualifies them.
      always_ff @(posedge clk) begin
        for (int j = 0; j < N; j++)
          d[j*DATA_WIDTH +: DATA_WIDTH] <=
            node_add(g_lvl[l-1].d[(2*j)*DATA_WIDTH +: DATA_WIDTH],
                     g_lvl[l-1].d[(2*j+1)*DATA_WIDTH +: DATA_WIDTH]);
      end
      // The valid and last flags move down the tree with the data.
      always_ff @(posedge clk) begin
        if (reset) begin
          v   <= 1'b0;
          lst <= 1'b0;
        end else begin
          v   <= g_lvl[l-1].v;
          lst <= g_lvl[l-1].lst;
        end
      end
    end
  end

  assign tree_sum = g_lvl[L].d;
  assign tree_v   = g_lvl[L].v;
  assign tree_l   = g_lvl[L].lst;

  // The first vector of a group replaces acc, so an old total never leaks
  // into a new group.
  assign sum = first ? tree_sum : node_add(acc, tree_sum);

  // Accumulate/output stage: pass each vector through, or add up a group and
  // emit one pulse when the last vector arrives.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      acc       <= '0;
      first     <= 1'b1;
    end else begin
      out_valid <= 1'b0;
      if (tree_v) begin
        if (ACCUM == 0) begin
          out_data  <= tree_sum;
          out_valid <= 1'b1;
        end else begin
          acc <= sum;
          if (tree_l) begin
            out_data  <= sum;
            out_valid <= 1'b1;
            first     <= 1'b1;
          end else begin
            first <= 1'b0;
          end
        end
      end
    end
  end

endmodule
